rotation_bram_ctrl: RTL and testbench

//  Sequencer for the dual-port 4x32 rotation/identity-matrix BRAM (2x2, row-major, addr=row*2+col).

---
 rtl/rotation_bram_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rotation_bram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_bram_ctrl.sv
// rtl/rotation_bram_ctrl.sv - dual-port sequencer for the 2x2 rotation/identity matrix BRAM
//
// Loads identity, writes a full 2x2 matrix and reads it back, using both BRAM ports
// in parallel (A: column 0, B: column 1 of the row being accessed).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   init_start/wr_start/rd_start  one-cycle requests, sampled only in IDLE (init > wr > rd)
//   w00..w11                      matrix to write, latched in the accept cycle
//   m00..m11, rd_valid            last matrix read, updated with the rd_valid pulse
//   init_done, wr_done, err       one-cycle completion / rejection pulses
//   busy, loaded                  operation in flight / BRAM holds valid contents
//   ena_*/wea_*/addr_*/din_*/dout_* BRAM port A and port B
module rotation_bram_ctrl #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 2,
    parameter logic [DATA_W-1:0] ONE_VAL = 32'h3F80_0000,
    parameter int                RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic              wr_start,
    input  logic              rd_start,
    input  logic [DATA_W-1:0] w00,
    input  logic [DATA_W-1:0] w01,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    output logic [DATA_W-1:0] m00,
    output logic [DATA_W-1:0] m01,
    output logic [DATA_W-1:0] m10,
    output logic [DATA_W-1:0] m11,
    output logic              rd_valid,
    output logic              init_done,
    output logic              wr_done,
    output logic              busy,
    output logic              loaded,
    output logic              err,
    output logic              ena_A,
    output logic              wea_A,
    output logic [ADDR_W-1:0] addr_A,
    output logic [DATA_W-1:0] din_A,
    input  logic [DATA_W-1:0] dout_A,
    output logic              ena_B,
    output logic              wea_B,
    output logic [ADDR_W-1:0] addr_B,
    output logic [DATA_W-1:0] din_B,
    input  logic [DATA_W-1:0] dout_B
);

    typedef enum logic [2:0] {
        IDLE, INIT0, INIT1, WR0, WR1, RD0, RD1, RD_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] w00_q, w01_q, w10_q, w11_q;
    logic [DATA_W-1:0] c00, c01;

    // Read tag pipe: stage k holds the pair issued k+1 cycles ago, so the last
    // stage lines up with the BRAM output for that issue.
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_pair;
    logic              issue_vld;
    logic              issue_pair;
    logic              last_capture;

    assign last_capture = tag_vld[RD_LAT-1] && tag_pair[RD_LAT-1];
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        ena_A      = 1'b0;
        wea_A      = 1'b0;
        addr_A     = '0;
        din_A      = '0;
        ena_B      = 1'b0;
        wea_B      = 1'b0;
        addr_B     = '0;
        din_B      = '0;
        issue_vld  = 1'b0;
        issue_pair = 1'b0;
        case (state)
            IDLE: begin
                if (init_start)
                    state_nxt = INIT0;
                else if (loaded && wr_start)
                    state_nxt = WR0;
                else if (loaded && rd_start)
                    state_nxt = RD0;
            end
            INIT0: begin
                {ena_A, wea_A, ena_B, wea_B} = 4'b1111;
                addr_A    = ADDR_W'(0);
                din_A     = ONE_VAL;
                addr_B    = ADDR_W'(1);
                state_nxt = INIT1;
            end
            INIT1: begin
                {ena_A, wea_A, ena_B, wea_B} = 4'b1111;
                addr_A    = ADDR_W'(2);
                addr_B    = ADDR_W'(3);
                din_B     = ONE_VAL;
                state_nxt = IDLE;
            end
            WR0: begin
                {ena_A, wea_A, ena_B, wea_B} = 4'b1111;
                addr_A    = ADDR_W'(0);
                din_A     = w00_q;
                addr_B    = ADDR_W'(1);
                din_B     = w01_q;
                state_nxt = WR1;
            end
            WR1: begin
                {ena_A, wea_A, ena_B, wea_B} = 4'b1111;
                addr_A    = ADDR_W'(2);
                din_A     = w10_q;
                addr_B    = ADDR_W'(3);
                din_B     = w11_q;
                state_nxt = IDLE;
            end
            RD0: begin
                ena_A     = 1'b1;
                ena_B     = 1'b1;
                addr_A    = ADDR_W'(0);
                addr_B    = ADDR_W'(1);
                issue_vld = 1'b1;
                state_nxt = RD1;
            end
            RD1: begin
                ena_A      = 1'b1;
                ena_B      = 1'b1;
                addr_A     = ADDR_W'(2);
                addr_B     = ADDR_W'(3);
                issue_vld  = 1'b1;
                issue_pair = 1'b1;
                state_nxt  = RD_WAIT;
            end
            RD_WAIT: begin
                if (last_capture)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            init_done <= 1'b0;
            wr_done   <= 1'b0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            loaded    <= 1'b0;
            w00_q     <= '0;
            w01_q     <= '0;
            w10_q     <= '0;
            w11_q     <= '0;
            c00       <= '0;
            c01       <= '0;
            m00       <= '0;
            m01       <= '0;
            m10       <= '0;
            m11       <= '0;
            tag_vld   <= '0;
            tag_pair  <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state == INIT1);
            wr_done   <= (state == WR1);
            // Init wins outright; otherwise any wr/rd while unloaded is rejected.
            err       <= (state == IDLE) && !init_start && !loaded && (wr_start || rd_start);
            rd_valid  <= 1'b0;
            if (state == INIT1)
                loaded <= 1'b1;
            // Only the last IDLE cycle (the accept cycle) matters for WR0/WR1.
            if (state == IDLE) begin
                w00_q <= w00;
                w01_q <= w01;
                w10_q <= w10;
                w11_q <= w11;
            end
            tag_vld[0]  <= issue_vld;
            tag_pair[0] <= issue_pair;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_pair[i] <= tag_pair[i-1];
            end
            // Row 0 is staged so all four outputs change together with rd_valid.
            if (tag_vld[RD_LAT-1]) begin
                if (!tag_pair[RD_LAT-1]) begin
                    c00 <= dout_A;
                    c01 <= dout_B;
                end else begin
                    m00      <= c00;
                    m01      <= c01;
                    m10      <= dout_A;
                    m11      <= dout_B;
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rotation_bram_ctrl.sv
// tb/tb_rotation_bram_ctrl.sv - directed self-checking bench, RD_LAT 2/1/3 instances
module tb_rotation_bram_ctrl;

    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_start = 1'b0, wr_start = 1'b0, rd_start = 1'b0;
    logic [31:0] w00 = '0, w01 = '0, w10 = '0, w11 = '0;

    logic        ena_a[3], wea_a[3], ena_b[3], wea_b[3];
    logic [1:0]  addr_a[3], addr_b[3];
    logic [31:0] din_a[3], din_b[3], dout_a[3], dout_b[3];
    logic [31:0] m00[3], m01[3], m10[3], m11[3];
    logic        rd_valid[3], init_done[3], wr_done[3], busy[3], loaded[3], err[3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 3);

        rotation_bram_ctrl #(.DATA_W(32), .ADDR_W(2), .ONE_VAL(ONE), .RD_LAT(LAT)) dut (
            .clk(clk), .rst(rst),
            .init_start(init_start), .wr_start(wr_start), .rd_start(rd_start),
            .w00(w00), .w01(w01), .w10(w10), .w11(w11),
            .m00(m00[k]), .m01(m01[k]), .m10(m10[k]), .m11(m11[k]),
            .rd_valid(rd_valid[k]), .init_done(init_done[k]), .wr_done(wr_done[k]),
            .busy(busy[k]), .loaded(loaded[k]), .err(err[k]),
            .ena_A(ena_a[k]), .wea_A(wea_a[k]), .addr_A(addr_a[k]), .din_A(din_a[k]), .dout_A(dout_a[k]),
            .ena_B(ena_b[k]), .wea_B(wea_b[k]), .addr_B(addr_b[k]), .din_B(din_b[k]), .dout_B(dout_b[k])
        );

        // BRAM model: data for an address presented in cycle c appears on dout in cycle c+LAT.
        logic [31:0] mem [4];
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        always @(posedge clk) begin
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pb[1] <= pb[0];
            pb[2] <= pb[1];
            pa[0] <= ena_a[k] ? mem[addr_a[k]] : 32'hDEAD_BEEF;
            pb[0] <= ena_b[k] ? mem[addr_b[k]] : 32'hDEAD_BEEF;
            if (ena_a[k] && wea_a[k]) mem[addr_a[k]] <= din_a[k];
            if (ena_b[k] && wea_b[k]) mem[addr_b[k]] <= din_b[k];
        end
        assign dout_a[k] = pa[LAT-1];
        assign dout_b[k] = pb[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read at cy0 and check rd_valid timing (cy3+RD_LAT) and data on all instances.
    task automatic do_read(input string tag, input logic [31:0] e00, input logic [31:0] e01,
                           input logic [31:0] e10, input logic [31:0] e11);
        int first[3];
        int npulse[3];
        int lat[3];
        first  = '{0, 0, 0};
        npulse = '{0, 0, 0};
        lat    = '{2, 1, 3};
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (rd_valid[k]) begin
                    npulse[k]++;
                    if (first[k] == 0) first[k] = c;
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_vcy%0d", tag, k), first[k], lat[k] + 3);
            check($sformatf("%s_npulse%0d", tag, k), npulse[k], 1);
            check($sformatf("%s_m00_%0d", tag, k), m00[k], e00);
            check($sformatf("%s_m01_%0d", tag, k), m01[k], e01);
            check($sformatf("%s_m10_%0d", tag, k), m10[k], e10);
            check($sformatf("%s_m11_%0d", tag, k), m11[k], e11);
        end
    endtask

    task automatic do_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        tick();
        check("init_done", init_done[0], 1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        tick();
        tick();
        check("rst_m00", m00[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_loaded", loaded[0], 0);
        check("rst_ena", ena_a[0], 0);
        rst = 1'b0;
        tick();

        // T2a: reads/writes before any init are rejected
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("rej_err", err[0], 1);
        check("rej_ena", ena_a[0], 0);
        check("rej_busy", busy[0], 0);
        tick();
        check("rej_err_clr", err[0], 0);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check("rej_wr_err", err[0], 1);
        check("rej_wr_ena", ena_b[0], 0);
        tick();

        // T1: identity load sequence
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("i1_ena", {ena_a[0], wea_a[0], ena_b[0], wea_b[0]}, 4'b1111);
        check("i1_addrA", addr_a[0], 0);
        check("i1_dinA", din_a[0], ONE);
        check("i1_addrB", addr_b[0], 1);
        check("i1_dinB", din_b[0], 0);
        check("i1_busy", busy[0], 1);
        tick();
        check("i2_addrA", addr_a[0], 2);
        check("i2_dinA", din_a[0], 0);
        check("i2_addrB", addr_b[0], 3);
        check("i2_dinB", din_b[0], ONE);
        check("i2_done", init_done[0], 0);
        tick();
        check("i3_done", init_done[0], 1);
        check("i3_loaded", loaded[0], 1);
        check("i3_busy", busy[0], 0);
        check("i3_ena", ena_a[0], 0);
        tick();
        check("i4_done", init_done[0], 0);

        // T2b: read back identity
        do_read("rd_id", ONE, 0, 0, ONE);

        // T3: write, w inputs change after accept
        w00 = 32'd1; w01 = 32'd2; w10 = 32'd3; w11 = 32'd4;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        w00 = 32'h99; w01 = 32'h99; w10 = 32'h99; w11 = 32'h99;
        check("w1_dinA", din_a[0], 1);
        check("w1_dinB", din_b[0], 2);
        tick();
        check("w2_dinA", din_a[0], 3);
        check("w2_addrB", addr_b[0], 3);
        check("w2_done", wr_done[0], 0);
        tick();
        check("w3_done", wr_done[0], 1);
        tick();
        do_read("rd_w", 1, 2, 3, 4);

        // T4: simultaneous requests, plus requests while busy
        init_start = 1'b1; wr_start = 1'b1; rd_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("pri_wea", wea_a[0], 1);
        check("pri_din", din_a[0], ONE);
        tick();
        wr_start = 1'b0; rd_start = 1'b0;
        tick();
        check("pri_idone", init_done[0], 1);
        check("pri_busy", busy[0], 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cnt += int'(wr_done[0]) + int'(rd_valid[0]) + int'(err[0]) + int'(busy[0]);
            tick();
        end
        check("pri_nopulse", cnt, 0);
        do_read("rd_pri", ONE, 0, 0, ONE);

        // Back-to-back init: done pulses 3 cycles apart
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        tick();
        check("b2b_done1", init_done[0], 1);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("b2b_busy", busy[0], 1);
        tick();
        tick();
        check("b2b_done2", init_done[0], 1);
        tick();

        // T5a: reset during WR1
        w00 = 32'd5; w01 = 32'd6; w10 = 32'd7; w11 = 32'd8;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rw_done", wr_done[0], 0);
        check("rw_loaded", loaded[0], 0);
        check("rw_busy", busy[0], 0);
        check("rw_ena", ena_a[0], 0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cnt += int'(wr_done[0]) + int'(busy[0]);
            tick();
        end
        check("rw_nodone", cnt, 0);

        // T5b: reset during RD_WAIT (m holds identity beforehand)
        do_init();
        tick();
        do_read("rd_pre", ONE, 0, 0, ONE);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        check("rr_busy", busy[0], 1);
        rst = 1'b1;
        tick();
        check("rr_m00", m00[0], 0);
        check("rr_m11", m11[0], 0);
        check("rr_valid", rd_valid[0], 0);
        check("rr_loaded", loaded[0], 0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cnt += int'(rd_valid[0]) + int'(rd_valid[1]) + int'(rd_valid[2]) + int'(busy[0]);
            tick();
        end
        check("rr_novalid", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
